// File: rtl/scan_reg_unit_pkg.sv
// Shared CPU constants and types for the scan register slice.
// WORD_LENGTH lives here so every scan chain in the CPU agrees on width.
package scan_reg_unit_pkg;

  localparam int CPU_WORD_LENGTH = 32;

  // Per-cell capture source: parallel load from d or shift from the chain.
  typedef enum logic {
    MODE_LOAD  = 1'b0,
    MODE_SHIFT = 1'b1
  } scan_mode_e;

  // Maps the raw scan_en pin onto the mode enum.
  function automatic scan_mode_e scan_mode(input logic scan_en);
    return scan_en ? MODE_SHIFT : MODE_LOAD;
  endfunction

endpackage

// File: rtl/scan_dff_cell.sv
// One bit of the scan register: an async-reset flop fed by a 2:1 mux
// choosing between the parallel input and the previous bit of the chain.
module scan_dff_cell
  import scan_reg_unit_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  input  logic i_scan_in,
  input  logic i_scan_en,
  output logic o_q
);

  scan_mode_e w_mode;
  logic       w_next;
  logic       r_q;

  assign w_mode = scan_mode(i_scan_en);
  assign w_next = (w_mode == MODE_SHIFT) ? i_scan_in : i_d;

  // Capture the muxed bit each rising edge; clear immediately when reset drops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/scan_reg_unit.sv
// Parallel-load register with a serial scan path.
// Bit 0 is the MSB; shifting moves data from bit 0 toward bit WORD_LENGTH-1,
// and the last bit doubles as the serial scan output.
module scan_reg_unit
  import scan_reg_unit_pkg::*;
#(
  parameter int WORD_LENGTH = CPU_WORD_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [0:WORD_LENGTH-1] d,
  output logic [0:WORD_LENGTH-1] q,
  input  logic                   scan_en = 1'b0,
  input  logic                   scan_in = 1'b0,
  output logic                   scan_out
);

  logic [0:WORD_LENGTH-1] w_q;
  logic [0:WORD_LENGTH-1] w_shift_src;

  // Bit 0 takes the external serial input; every other bit takes its neighbour.
  assign w_shift_src[0] = scan_in;

  genvar gi;
  generate
    for (gi = 1; gi < WORD_LENGTH; gi++) begin : g_chain
      assign w_shift_src[gi] = w_q[gi-1];
    end

    for (gi = 0; gi < WORD_LENGTH; gi++) begin : g_cell
      scan_dff_cell u_cell (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_d       (d[gi]),
        .i_scan_in (w_shift_src[gi]),
        .i_scan_en (scan_en),
        .o_q       (w_q[gi])
      );
    end
  endgenerate

  assign q        = w_q;
  assign scan_out = w_q[WORD_LENGTH-1];

endmodule

// File: tb/tb_scan_reg_unit.sv
// Directed self-checking bench for scan_reg_unit (32-bit default width).
module tb_scan_reg_unit;

  logic        clk;
  logic        rst;
  logic [0:31] d;
  logic [0:31] q;
  logic        scan_en;
  logic        scan_in;
  logic        scan_out;

  int checks;
  int errors;

  scan_reg_unit dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .q        (q),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out)
  );

  // 20 ns clock period.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    d       = 32'hFFFFFFFF;
    scan_en = 1'b0;
    scan_in = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) scan_en = 1'b1;
      tick();
      checks++;
      if (q !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_q cycle %0d: got %h expected 00000000", i, q);
      end
      checks++;
      if (scan_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_scan_out cycle %0d: got %b expected 0", i, scan_out);
      end
    end
  endtask

  task automatic test_load();
    scan_en = 1'b0;
    scan_in = 1'b0;
    rst     = 1'b1;
    d       = 32'h00000001;
    tick();
    checks++;
    if (q !== 32'h00000001) begin
      errors++;
      $display("[TB] FAIL load_one: got %h expected 00000001", q);
    end
    checks++;
    if (scan_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_one_scan_out: got %b expected 1", scan_out);
    end
    d = 32'h00000000;
    tick();
    checks++;
    if (q !== 32'h00000000) begin
      errors++;
      $display("[TB] FAIL load_zero: got %h expected 00000000", q);
    end
    d = 32'hDEADBEEF;
    tick();
    checks++;
    if (q !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL load_deadbeef: got %h expected deadbeef", q);
    end
  endtask

  task automatic test_shift_one();
    scan_en = 1'b0;
    d       = 32'h80000001;
    tick();
    checks++;
    if (q !== 32'h80000001) begin
      errors++;
      $display("[TB] FAIL shift_preload: got %h expected 80000001", q);
    end
    scan_en = 1'b1;
    scan_in = 1'b0;
    d       = 32'hFFFFFFFF;
    tick();
    checks++;
    if (q !== 32'h40000000) begin
      errors++;
      $display("[TB] FAIL shift_one_q: got %h expected 40000000", q);
    end
    checks++;
    if (scan_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL shift_one_scan_out: got %b expected 0", scan_out);
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_q;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    scan_en = 1'b1;
    scan_in = 1'b1;
    d       = 32'h00000000;
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_q = ~(32'hFFFFFFFF >> k);
      checks++;
      if (q !== exp_q) begin
        errors++;
        $display("[TB] FAIL fill_q edge %0d: got %h expected %h", k, q, exp_q);
      end
      checks++;
      if (scan_out !== (k == 32)) begin
        errors++;
        $display("[TB] FAIL fill_scan_out edge %0d: got %b expected %b", k, scan_out, (k == 32));
      end
    end
  endtask

  task automatic test_async_reset();
    scan_en = 1'b0;
    d       = 32'hA5A5A5A5;
    tick();
    checks++;
    if (q !== 32'hA5A5A5A5) begin
      errors++;
      $display("[TB] FAIL async_preload: got %h expected a5a5a5a5", q);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (q !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_clear: got %h expected 00000000", q);
    end
    checks++;
    if (scan_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_clear_scan_out: got %b expected 0", scan_out);
    end
    #3;
    rst = 1'b1;
    d   = 32'h12345678;
    tick();
    checks++;
    if (q !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL async_release_load: got %h expected 12345678", q);
    end
  endtask

  task automatic test_between_edges();
    scan_en = 1'b0;
    d       = 32'h11111111;
    tick();
    #2;
    d = 32'h22222222;
    #3;
    checks++;
    if (q !== 32'h11111111) begin
      errors++;
      $display("[TB] FAIL hold_after_d_change: got %h expected 11111111", q);
    end
    d = 32'h33333333;
    #10;
    checks++;
    if (q !== 32'h11111111) begin
      errors++;
      $display("[TB] FAIL hold_before_edge: got %h expected 11111111", q);
    end
    tick();
    checks++;
    if (q !== 32'h33333333) begin
      errors++;
      $display("[TB] FAIL load_at_edge: got %h expected 33333333", q);
    end
    scan_en = 1'b1;
    scan_in = 1'b1;
    #4;
    scan_in = 1'b0;
    tick();
    checks++;
    if (q !== 32'h19999999) begin
      errors++;
      $display("[TB] FAIL scan_in_glitch: got %h expected 19999999", q);
    end
  endtask

  task automatic test_back_to_back();
    scan_en = 1'b0;
    d       = 32'hF0000000;
    tick();
    scan_en = 1'b1;
    scan_in = 1'b1;
    tick();
    checks++;
    if (q !== 32'hF8000000) begin
      errors++;
      $display("[TB] FAIL b2b_shift: got %h expected f8000000", q);
    end
    scan_en = 1'b0;
    d       = 32'h0000000F;
    tick();
    checks++;
    if (q !== 32'h0000000F) begin
      errors++;
      $display("[TB] FAIL b2b_load: got %h expected 0000000f", q);
    end
    scan_en = 1'b1;
    scan_in = 1'b0;
    tick();
    checks++;
    if (q !== 32'h00000007) begin
      errors++;
      $display("[TB] FAIL b2b_shift_again: got %h expected 00000007", q);
    end
    scan_in = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (q !== 32'hE0000000) begin
      errors++;
      $display("[TB] FAIL midscan_partial: got %h expected e0000000", q);
    end
    #4;
    rst = 1'b0;
    #2;
    rst     = 1'b1;
    scan_in = 1'b0;
    tick();
    checks++;
    if (q !== 32'h00000000) begin
      errors++;
      $display("[TB] FAIL midscan_discard: got %h expected 00000000", q);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    d       = '0;
    scan_en = 1'b0;
    scan_in = 1'b0;
    test_reset();
    test_load();
    test_shift_one();
    test_fill();
    test_async_reset();
    test_between_edges();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_reg_unit.md
SCAN_REG_UNIT -- requirements
Module: scan_reg_unit

Interface
REQ-001 Parameter: WORD_LENGTH, default 32 (shared WORD_LENGTH constant), register width in bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: d  input  [0:WORD_LENGTH-1]  parallel data in, bit 0 = MSB.
REQ-006 Port: q  output  [0:WORD_LENGTH-1]  registered data out, bit 0 = MSB.
REQ-007 Port: scan_en  input  1  scan-shift select; port default value 0 when left unconnected.
REQ-008 Port: scan_in  input  1  serial scan data in; port default value 0 when left unconnected.
REQ-009 Port: scan_out  output  1  serial scan data out, equals q[WORD_LENGTH-1].

Function
REQ-010 With rst high and scan_en=0, on each rising clk edge q SHALL load d (latency 1 cycle).
REQ-011 With rst high and scan_en=1, on each rising clk edge the register SHALL shift toward the LSB: q[0] <= scan_in, q[i] <= q[i-1] for i = 1..WORD_LENGTH-1; d is ignored.
REQ-012 scan_out SHALL be combinationally equal to q[WORD_LENGTH-1] at all times, no extra register stage.
REQ-013 q SHALL change only on a rising clk edge or on reset assertion; changes to d or scan_in between edges SHALL NOT affect q.
REQ-014 Shifting WORD_LENGTH cycles SHALL fully replace the contents; after WORD_LENGTH cycles scan_out presents the first scan_in bit shifted in.
REQ-015 A scan_en change takes effect at the next rising edge; no mode-switch latency or lost cycle.
REQ-016 There SHALL be no internal state other than the WORD_LENGTH register bits.

Reset
REQ-017 When rst goes low, q SHALL become all-zero immediately, independent of clk; scan_out SHALL become 0.
REQ-018 While rst is low, q SHALL hold zero regardless of clk, d, scan_en and scan_in.
REQ-019 The first rising clk edge after rst returns high SHALL perform a normal load or shift; rst deassertion coincident with an edge SHALL cause no capture on that edge.
REQ-020 Reset asserted mid-scan SHALL discard all partially shifted data.

Structure
REQ-021 WORD_LENGTH SHALL come from the shared CPU constants package/include, not be redefined locally.
REQ-022 One sub-module, scan_dff_cell (1-bit async-reset flop with 2:1 mux between d and scan-in), SHALL be instantiated WORD_LENGTH times via generate, chained bit i-1 -> bit i.

Verification
REQ-023 rst=0 with d=32'hFFFFFFFF and clocks running -> q=0, scan_out=0 throughout.
REQ-024 rst=1, scan_en=0, d=1 applied before edge -> q=32'h00000001 after next rising edge; d=0 -> q=0 after following edge.
REQ-025 Load d=32'h80000001, then scan_en=1, scan_in=0 for 1 edge -> q=32'h40000000, scan_out=0.
REQ-026 After reset, scan_en=1, scan_in=1 for 32 edges -> q=32'hFFFFFFFF; scan_out first becomes 1 after edge 32.
REQ-027 q=32'hA5A5A5A5 loaded, drive rst=0 between clock edges -> q=0 before next edge; release rst, d=32'h12345678 -> q=32'h12345678 after next edge.
REQ-028 d toggled between edges with clk period 20 ns -> q changes only at rising edges.
